// File: rtl/mem_pkg.sv
// Shared definitions for the row-memory read and write blocks: geometry defaults and FSM encoding.
package mem_pkg;

  localparam int unsigned ROWS_DEF   = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned WR_LAT_DEF = 2;

  // Latency counter holds up to WR_LAT-1 with WR_LAT <= 15
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT   = 2'd1;
  localparam logic [ST_W-1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/mem_wr_ctrl.sv
// Write controller: request latching, fixed-latency sequencing, ready/busy/drop pulses.
// With BYTE_MASK_EN defined a per-byte enable is latched alongside the data.
module mem_wr_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned WR_LAT = WR_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   row_i,
  input  logic [DATA_W-1:0]   data_i,
`ifdef BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W/8-1:0] wr_be_o,
`endif
  output logic                commit_c_o,
  output logic [ADDR_W-1:0]   wr_row_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                drop_o
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              commit_c;
`ifdef BYTE_MASK_EN
  logic [DATA_W/8-1:0] be_q, be_d;
`endif

  // Next-state and pulse generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    drop_d   = 1'b0;
    commit_c = 1'b0;
`ifdef BYTE_MASK_EN
    be_d     = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (32'(row_i) < ROWS) begin
            row_d   = row_i;
            data_d  = data_i;
`ifdef BYTE_MASK_EN
            be_d    = be_i;
`endif
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(WR_LAT - 1);
            state_d = (WR_LAT == 1) ? ST_COMMIT : ST_WAIT;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        drop_d = valid_i;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        drop_d   = valid_i;
        commit_c = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
`ifdef BYTE_MASK_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
`ifdef BYTE_MASK_EN
      be_q    <= be_d;
`endif
    end
  end

  assign commit_c_o = commit_c;
  assign wr_row_o   = row_q;
  assign wr_data_o  = data_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign drop_o     = drop_q;
`ifdef BYTE_MASK_EN
  assign wr_be_o    = be_q;
`endif

endmodule

// File: rtl/mem_row_writer.sv
// Row memory write port: fixed-latency row writes with a combinational peek port.
// Define BYTE_MASK_EN to add a byte_en input that masks which bytes a commit updates.
module mem_row_writer
  import mem_pkg::*;
#(
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned WR_LAT = WR_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   row,
  input  logic [DATA_W-1:0]   data,
  input  logic                input_valid,
`ifdef BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic                ready,
  output logic                busy,
  output logic                drop,
  input  logic [ADDR_W-1:0]   peek_row,
  output logic [DATA_W-1:0]   peek_data
);

  logic              commit_c;
  logic [ADDR_W-1:0] wr_row;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_q [ROWS];
`ifdef BYTE_MASK_EN
  logic [DATA_W/8-1:0] wr_be;
`endif

  mem_wr_ctrl #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WR_LAT (WR_LAT)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (input_valid),
    .row_i      (row),
    .data_i     (data),
`ifdef BYTE_MASK_EN
    .be_i       (byte_en),
    .wr_be_o    (wr_be),
`endif
    .commit_c_o (commit_c),
    .wr_row_o   (wr_row),
    .wr_data_o  (wr_data),
    .ready_o    (ready),
    .busy_o     (busy),
    .drop_o     (drop)
  );

  // Storage array; the latched row was range-checked at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit_c) begin
`ifdef BYTE_MASK_EN
      for (int b = 0; b < int'(DATA_W / 8); b++) begin
        if (wr_be[b]) begin
          mem_q[wr_row][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
`else
      mem_q[wr_row] <= wr_data;
`endif
    end
  end

  assign peek_data = (32'(peek_row) < ROWS) ? mem_q[peek_row] : '0;

endmodule

// File: tb/tb_mem_row_writer.sv
// Self-checking bench for mem_row_writer: directed scenarios plus randomized traffic vs a reference model.
module tb_mem_row_writer;

  localparam int unsigned ROWS   = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WR_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] row;
  logic [DATA_W-1:0] data;
  logic              input_valid;
  logic              ready, busy, drop;
  logic [ADDR_W-1:0] peek_row;
  logic [DATA_W-1:0] peek_data;
`ifdef BYTE_MASK_EN
  logic [DATA_W/8-1:0] byte_en;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_row_writer #(
    .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_LAT(WR_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .data        (data),
    .input_valid (input_valid),
`ifdef BYTE_MASK_EN
    .byte_en     (byte_en),
`endif
    .ready       (ready),
    .busy        (busy),
    .drop        (drop),
    .peek_row    (peek_row),
    .peek_data   (peek_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    input_valid = v;
    row         = r;
    data        = d;
`ifdef BYTE_MASK_EN
    byte_en     = '1;
`endif
  endtask

  task automatic write_row(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    drive(1'b1, r, d);
    tick();
    drive(1'b0, '0, '0);
    repeat (WR_LAT) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    peek_row = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({ready, busy, drop} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got rdy/busy/drop=%b want 000", {ready, busy, drop});
    end
    for (int i = 0; i < int'(ROWS); i++) begin
      peek_row = ADDR_W'(i);
      #1;
      n_cmp++; if (peek_data !== '0) begin
        n_err++; $display("FAIL reset_peek row %0d: got %h want 0", i, peek_data);
      end
    end
  endtask

  task automatic test_basic();
    peek_row = 4'd12;
    drive(1'b1, 4'd12, 32'hDEADBEEF);
    tick();
    drive(1'b0, '0, '0);
    n_cmp++; if ({ready, busy} !== 2'b01) begin
      n_err++; $display("FAIL basic_e0: got rdy/busy=%b want 01", {ready, busy});
    end
    n_cmp++; if (peek_data !== 32'h0) begin
      n_err++; $display("FAIL basic_old_peek: got %h want 0", peek_data);
    end
    tick();
    n_cmp++; if ({ready, busy} !== 2'b01) begin
      n_err++; $display("FAIL basic_e1: got rdy/busy=%b want 01", {ready, busy});
    end
    tick();
    n_cmp++; if ({ready, busy, drop} !== 3'b100) begin
      n_err++; $display("FAIL basic_e2: got rdy/busy/drop=%b want 100", {ready, busy, drop});
    end
    n_cmp++; if (peek_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL basic_peek: got %h want deadbeef", peek_data);
    end
    peek_row = 4'd11;
    #1;
    n_cmp++; if (peek_data !== 32'h0) begin
      n_err++; $display("FAIL basic_other_row: got %h want 0", peek_data);
    end
    tick();
    n_cmp++; if (ready !== 1'b0) begin
      n_err++; $display("FAIL basic_ready_pulse: got %b want 0", ready);
    end
  endtask

  task automatic test_cadence();
    logic [ADDR_W-1:0] rows [5];
    int                drops;
    rows  = '{4'd1, 4'd11, 4'd14, 4'd9, 4'd10};
    drops = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, rows[k], DATA_W'(rows[k]) * 32'd100);
      tick();
      drops += int'(drop);
      drive(1'b0, '0, '0);
      for (int c = 1; c <= int'(WR_LAT); c++) begin
        if (c == int'(WR_LAT)) peek_row = rows[k];
        tick();
        drops += int'(drop);
        n_cmp++; if (ready !== (c == int'(WR_LAT))) begin
          n_err++; $display("FAIL cadence_ready k=%0d c=%0d: got %b", k, c, ready);
        end
      end
      n_cmp++; if (peek_data !== DATA_W'(rows[k]) * 32'd100) begin
        n_err++; $display("FAIL cadence_peek row %0d: got %0d want %0d", rows[k], peek_data, rows[k] * 100);
      end
    end
    n_cmp++; if (drops !== 0) begin
      n_err++; $display("FAIL cadence_drop: got %0d drops want 0", drops);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'd5, 32'd7);
    tick();
    drive(1'b1, 4'd6, 32'd8);
    tick();
    drive(1'b0, '0, '0);
    n_cmp++; if (drop !== 1'b1) begin
      n_err++; $display("FAIL collision_drop: got %b want 1", drop);
    end
    tick();
    n_cmp++; if ({ready, drop} !== 2'b10) begin
      n_err++; $display("FAIL collision_commit: got rdy/drop=%b want 10", {ready, drop});
    end
    peek_row = 4'd5;
    #1;
    n_cmp++; if (peek_data !== 32'd7) begin
      n_err++; $display("FAIL collision_row5: got %0d want 7", peek_data);
    end
    peek_row = 4'd6;
    #1;
    n_cmp++; if (peek_data !== 32'd0) begin
      n_err++; $display("FAIL collision_row6: got %0d want 0", peek_data);
    end
    tick();
  endtask

  task automatic test_overwrite();
    write_row(4'd14, 32'd1);
    write_row(4'd14, 32'd2);
    peek_row = 4'd14;
    #1;
    n_cmp++; if (peek_data !== 32'd2) begin
      n_err++; $display("FAIL overwrite_peek: got %0d want 2", peek_data);
    end
    tick();
  endtask

  task automatic test_abort();
    int rdy_seen;
    rdy_seen = 0;
    drive(1'b1, 4'd3, 32'd55);
    tick();
    drive(1'b0, '0, '0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ready, busy} !== 2'b00) begin
      n_err++; $display("FAIL abort_async: got rdy/busy=%b want 00", {ready, busy});
    end
    repeat (2) begin tick(); rdy_seen += int'(ready); end
    rst_n = 1'b1;
    repeat (3) begin tick(); rdy_seen += int'(ready); end
    n_cmp++; if (rdy_seen !== 0) begin
      n_err++; $display("FAIL abort_ready: got %0d pulses want 0", rdy_seen);
    end
    peek_row = 4'd3;
    #1;
    n_cmp++; if (peek_data !== 32'd0) begin
      n_err++; $display("FAIL abort_row3: got %0d want 0", peek_data);
    end
    peek_row = 4'd14;
    #1;
    n_cmp++; if (peek_data !== 32'd0) begin
      n_err++; $display("FAIL abort_row14: got %0d want 0", peek_data);
    end
  endtask

`ifdef BYTE_MASK_EN
  task automatic test_byte_mask();
    write_row(4'd2, 32'hFFFFFFFF);
    input_valid = 1'b1; row = 4'd2; data = 32'h0; byte_en = 4'b0101;
    tick();
    drive(1'b0, '0, '0);
    repeat (WR_LAT) tick();
    peek_row = 4'd2;
    #1;
    n_cmp++; if (peek_data !== 32'hFF00FF00) begin
      n_err++; $display("FAIL mask_0101: got %h want ff00ff00", peek_data);
    end
    input_valid = 1'b1; row = 4'd2; data = 32'h12345678; byte_en = 4'b0000;
    tick();
    drive(1'b0, '0, '0);
    repeat (WR_LAT) tick();
    n_cmp++; if ({ready, peek_data} !== {1'b1, 32'hFF00FF00}) begin
      n_err++; $display("FAIL mask_zero: got rdy=%b data=%h want 1 ff00ff00", ready, peek_data);
    end
    tick();
  endtask
`endif

  // Reference model: a write is pending for WR_LAT edges after acceptance
  task automatic test_random();
    logic [DATA_W-1:0]   exp_mem [ROWS];
    logic [DATA_W-1:0]   p_data;
    logic [ADDR_W-1:0]   p_row;
    logic [DATA_W/8-1:0] p_be, cur_be;
    int                  p_left;
    logic                pend, was_busy, e_ready, e_drop, v;
    logic [ADDR_W-1:0]   r;
    logic [DATA_W-1:0]   d;
    do_reset();
    for (int i = 0; i < int'(ROWS); i++) exp_mem[i] = '0;
    pend = 1'b0; p_left = 0; p_row = '0; p_data = '0; p_be = '1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v      = ($urandom_range(0, 2) == 0);
      r      = ADDR_W'($urandom_range(0, ROWS - 1));
      d      = $urandom;
      cur_be = '1;
      drive(v, r, d);
`ifdef BYTE_MASK_EN
      cur_be  = DATA_W'($urandom) >> (DATA_W - DATA_W / 8);
      byte_en = cur_be;
`endif
      was_busy = pend;
      e_ready  = 1'b0;
      e_drop   = 1'b0;
      if (pend) begin
        p_left--;
        if (p_left == 0) begin
          for (int b = 0; b < int'(DATA_W / 8); b++)
            if (p_be[b]) exp_mem[p_row][8*b +: 8] = p_data[8*b +: 8];
          e_ready = 1'b1;
          pend    = 1'b0;
        end
      end
      if (v) begin
        if (was_busy || 32'(r) >= ROWS) e_drop = 1'b1;
        else begin
          pend = 1'b1; p_left = int'(WR_LAT); p_row = r; p_data = d; p_be = cur_be;
        end
      end
      peek_row = ADDR_W'($urandom_range(0, ROWS - 1));
      tick();
      n_cmp++; if ({ready, busy, drop} !== {e_ready, pend, e_drop}) begin
        n_err++; $display("FAIL rand_flags cyc %0d: got rdy/busy/drop=%b want %b", cyc, {ready, busy, drop}, {e_ready, pend, e_drop});
      end
      n_cmp++; if (peek_data !== exp_mem[peek_row]) begin
        n_err++; $display("FAIL rand_peek cyc %0d row %0d: got %h want %h", cyc, peek_row, peek_data, exp_mem[peek_row]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    peek_row = '0;
    test_reset();
    test_basic();
    test_cadence();
    test_collision();
    test_overwrite();
    test_abort();
`ifdef BYTE_MASK_EN
    test_byte_mask();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
